// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame sequencer slice.
//   state_t      - sequencer state, 2-bit encoding visible on the STATE port
//   PAT_*        - pattern indices understood by the pixel datapath
//   DEFAULT_DEBOUNCE_CYCLES - 10 ms of stable level at a 9 MHz pixel clock
//   next_pattern - wrapping pattern-index increment
package lcd_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    BLANKING  = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [2:0] PAT_CHECKER = 3'd0;
  localparam logic [2:0] PAT_BARS    = 3'd1;
  localparam logic [2:0] PAT_GRAD    = 3'd2;
  localparam logic [2:0] PAT_SOLID   = 3'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 90000;

  // Advance a pattern index, wrapping to 0 after the last legal index.
  function automatic logic [2:0] next_pattern(input logic [2:0] cur,
                                              input logic [2:0] last);
    return (cur == last) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one asynchronous, active-low push button.
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset
//   btn_n  - raw button, pressed = 0
//   press  - one-cycle pulse when the debounced level goes 1 -> 0
// A new level is accepted only after it has been seen continuously for
// DEBOUNCE_CYCLES cycles after synchronization. Release raises no event.
module btn_debounce
  import lcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == LAST) begin
          stable <= sync2;
          cnt    <= '0;
          // Only the falling (press) edge of the debounced level is an event.
          press  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any return to the stable level restarts the qualification window.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Panel bring-up and test-pattern sequencer, clocked by the LCD pixel clock.
//   LCD_CLK   - pixel clock
//   BTN_RESET - asynchronous active-low reset
//   PLL_LOCK  - PLL lock flag (asynchronous, synchronized here)
//   BTN_USER  - raw user button, pressed = 0 (asynchronous)
//   VSYNC     - vertical sync, synchronous to LCD_CLK
//   PAT_SEL   - pattern index for the pixel datapath
//   BLANK     - 1 = datapath drives black
//   BL_EN     - backlight enable
//   FRAME_CNT - frame starts seen while running (wraps)
//   STATE     - current sequencer state
// The panel stays blanked until lock plus BLANK_FRAMES frame starts. Button
// presses are collected and applied as a single advance on the next frame
// start, so a frame never shows a mix of two patterns.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BLANK_FRAMES     = 4,
  parameter int NUM_PATTERNS     = 4,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic        LCD_CLK,
  input  logic        BTN_RESET,
  input  logic        PLL_LOCK,
  input  logic        BTN_USER,
  input  logic        VSYNC,
  output logic [2:0]  PAT_SEL,
  output logic        BLANK,
  output logic        BL_EN,
  output logic [15:0] FRAME_CNT,
  output logic [1:0]  STATE
);

  // Inactive VSYNC level: high for an active-low sync.
  localparam logic       VS_IDLE    = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] LAST_BLANK = 8'(BLANK_FRAMES - 1);
  localparam logic [2:0] LAST_PAT   = 3'(NUM_PATTERNS - 1);

  logic       lock_s1;
  logic       lock_s;
  logic       vs_q;
  logic       frame_start;
  logic       press;
  logic       pending;
  logic [7:0] blank_cnt;
  state_t     state;
  state_t     next_state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (LCD_CLK),
    .rst_n (BTN_RESET),
    .btn_n (BTN_USER),
    .press (press)
  );

  // Inactive-to-active transition of VSYNC marks the start of a frame.
  assign frame_start = (vs_q == VS_IDLE) && (VSYNC != VS_IDLE);

  assign STATE = state;

  // NOTE: next_state gets its default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: if (lock_s) next_state = BLANKING;
      BLANKING:  if (frame_start && (blank_cnt == LAST_BLANK)) next_state = RUN;
      RUN:       next_state = RUN;
      default:   next_state = WAIT_LOCK;
    endcase
    // Loss of lock overrides everything, including a same-cycle frame start.
    if (!lock_s) next_state = WAIT_LOCK;
  end

  always_ff @(posedge LCD_CLK or negedge BTN_RESET) begin
    if (!BTN_RESET) begin
      lock_s1   <= 1'b0;
      lock_s    <= 1'b0;
      vs_q      <= VS_IDLE;
      state     <= WAIT_LOCK;
      blank_cnt <= '0;
      pending   <= 1'b0;
      PAT_SEL   <= 3'd0;
      FRAME_CNT <= 16'd0;
      BLANK     <= 1'b1;
      BL_EN     <= 1'b0;
    end else begin
      lock_s1 <= PLL_LOCK;
      lock_s  <= lock_s1;
      vs_q    <= VSYNC;
      state   <= next_state;

      // Panel controls follow the upcoming state so they change on the
      // same edge as STATE.
      BLANK <= (next_state != RUN);
      BL_EN <= (next_state == RUN);

      // Held at zero outside BLANKING, so it starts from zero on entry.
      if (state != BLANKING) begin
        blank_cnt <= '0;
      end else if (frame_start) begin
        blank_cnt <= blank_cnt + 8'd1;
      end

      if ((state == RUN) && lock_s) begin
        if (frame_start) begin
          FRAME_CNT <= FRAME_CNT + 16'd1;
          if (pending) PAT_SEL <= next_pattern(PAT_SEL, LAST_PAT);
        end
        // A press coinciding with a frame start is kept for the next frame;
        // any number of earlier presses collapse into the one advance.
        pending <= press || (pending && !frame_start);
      end else begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
`timescale 1ns/1ps
module tb_lcd_frame_sequencer;
  import lcd_pkg::*;

  localparam int DEB = 16;
  localparam int BF  = 4;
  localparam int NP  = 4;

  logic        LCD_CLK = 1'b0;
  logic        BTN_RESET;
  logic        PLL_LOCK;
  logic        BTN_USER;
  logic        VSYNC;
  logic [2:0]  PAT_SEL;
  logic        BLANK;
  logic        BL_EN;
  logic [15:0] FRAME_CNT;
  logic [1:0]  STATE;

  always #5 LCD_CLK = ~LCD_CLK;

  lcd_frame_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .BLANK_FRAMES    (BF),
    .NUM_PATTERNS    (NP),
    .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .LCD_CLK  (LCD_CLK),
    .BTN_RESET(BTN_RESET),
    .PLL_LOCK (PLL_LOCK),
    .BTN_USER (BTN_USER),
    .VSYNC    (VSYNC),
    .PAT_SEL  (PAT_SEL),
    .BLANK    (BLANK),
    .BL_EN    (BL_EN),
    .FRAME_CNT(FRAME_CNT),
    .STATE    (STATE)
  );

  typedef struct {
    string       tag;
    state_t      st;
    logic        blank;
    logic        bl_en;
    logic [2:0]  pat;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Transaction-level reference model
  state_t      m_state;
  int          m_bcnt;
  logic [2:0]  m_pat;
  logic [15:0] m_fcnt;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag   = tag;
    e.st    = m_state;
    e.blank = (m_state != RUN);
    e.bl_en = (m_state == RUN);
    e.pat   = m_pat;
    e.fcnt  = m_fcnt;
    sb.push_back(e);
  endtask

  task automatic compare_expect();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".state"}, 32'(STATE),     32'(e.st));
      check({e.tag, ".blank"}, 32'(BLANK),     32'(e.blank));
      check({e.tag, ".bl_en"}, 32'(BL_EN),     32'(e.bl_en));
      check({e.tag, ".pat"},   32'(PAT_SEL),   32'(e.pat));
      check({e.tag, ".fcnt"},  32'(FRAME_CNT), 32'(e.fcnt));
    end
  endtask

  // Falling VSYNC edge driven at a negedge; outputs compared one cycle later.
  task automatic frame(input string tag);
    VSYNC = 1'b0;
    if (m_state == BLANKING) begin
      m_bcnt++;
      if (m_bcnt == BF) m_state = RUN;
    end else if (m_state == RUN) begin
      m_fcnt = m_fcnt + 16'd1;
      if (m_pend) begin
        m_pat  = (int'(m_pat) == NP - 1) ? 3'd0 : 3'(m_pat + 3'd1);
        m_pend = 1'b0;
      end
    end
    push_expect(tag);
    @(negedge LCD_CLK);
    compare_expect();
    repeat (3) @(negedge LCD_CLK);
    VSYNC = 1'b1;
    repeat (4) @(negedge LCD_CLK);
  endtask

  // Clean press and release, each held well beyond the debounce window.
  task automatic press(input string tag);
    BTN_USER = 1'b0;
    repeat (DEB + 8) @(negedge LCD_CLK);
    BTN_USER = 1'b1;
    repeat (DEB + 8) @(negedge LCD_CLK);
    if (m_state == RUN) m_pend = 1'b1;
    // Nothing visible may change mid-frame.
    push_expect(tag);
    compare_expect();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    BTN_RESET = 1'b0;
    PLL_LOCK  = 1'b0;
    BTN_USER  = 1'b1;
    VSYNC     = 1'b1;
    m_state   = WAIT_LOCK;
    m_bcnt    = 0;
    m_pat     = 3'd0;
    m_fcnt    = 16'd0;
    m_pend    = 1'b0;

    repeat (3) @(negedge LCD_CLK);
    push_expect("reset");
    compare_expect();

    // Lock bring-up
    BTN_RESET = 1'b1;
    repeat (1000) @(negedge LCD_CLK);
    push_expect("no_lock");
    compare_expect();
    PLL_LOCK = 1'b1;
    repeat (2) @(negedge LCD_CLK);
    push_expect("lock_plus2");
    compare_expect();
    @(negedge LCD_CLK);
    m_state = BLANKING;
    m_bcnt  = 0;
    push_expect("lock_plus3");
    compare_expect();
    frame("blank_f1");
    frame("blank_f2");
    frame("blank_f3");
    push_expect("before_f4");
    compare_expect();
    frame("run_f4");
    frame("run_f5");
    frame("run_f6");

    // Bouncing button shorter than the debounce window: no press
    for (int i = 0; i < 10; i++) begin
      BTN_USER = ~BTN_USER;
      repeat (8) @(negedge LCD_CLK);
    end
    frame("bounce_no_adv");
    press("press_midframe");
    frame("press_adv");
    frame("no_double_adv");

    // Several presses per frame collapse to one advance; wraps 3 -> 0
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 3; p++) press("multi_press");
      frame("multi_adv");
    end

    // Press pulse coincident with frame start: applied one frame later
    BTN_USER = 1'b0;
    repeat (DEB + 2) @(negedge LCD_CLK);
    frame("coincident");
    m_pend = 1'b1;
    BTN_USER = 1'b1;
    repeat (DEB + 8) @(negedge LCD_CLK);
    frame("after_coincident");

    press("to_pat1");
    frame("pat1");
    press("to_pat2");
    frame("pat2");

    // Lock loss mid-RUN
    PLL_LOCK = 1'b0;
    repeat (3) @(negedge LCD_CLK);
    m_state = WAIT_LOCK;
    m_pend  = 1'b0;
    push_expect("lock_loss");
    compare_expect();
    repeat (47) @(negedge LCD_CLK);
    PLL_LOCK = 1'b1;
    repeat (3) @(negedge LCD_CLK);
    m_state = BLANKING;
    m_bcnt  = 0;
    push_expect("relock");
    compare_expect();
    press("press_blanking");
    frame("reblank_f1");
    frame("reblank_f2");
    frame("reblank_f3");
    frame("rerun_f4");
    frame("rerun_f5");

    // Asynchronous reset between clock edges
    @(posedge LCD_CLK);
    #2;
    BTN_RESET = 1'b0;
    #1;
    m_state = WAIT_LOCK;
    m_pat   = 3'd0;
    m_fcnt  = 16'd0;
    m_pend  = 1'b0;
    push_expect("async_reset");
    compare_expect();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
Name: lcd_frame_sequencer

Overview:
- Control block between the PLL/LCD timing generator and the pixel pattern datapath. Runs on the LCD pixel clock.
- Holds the panel blanked until the PLL has locked and a set number of clean frames have passed. Then enables the backlight.
- Debounces the user button and advances the test-pattern select, applied only on frame boundaries so no frame shows a mixed pattern.

Parameters:
- DEBOUNCE_CYCLES, 90000, number of stable pixel-clock cycles before a button level is accepted (10 ms at 9 MHz).
- BLANK_FRAMES, 4, number of frame starts spent blanked after lock before RUN; legal range 1..255.
- NUM_PATTERNS, 4, number of selectable patterns; PAT_SEL wraps at NUM_PATTERNS-1; legal range 2..8.
- VSYNC_ACTIVE_LOW, 1, when 1 a frame start is the falling edge of VSYNC, otherwise the rising edge.

Ports:
- LCD_CLK  input  1  pixel clock; all state is clocked on its rising edge.
- BTN_RESET  input  1  reset, asynchronous, active-low.
- PLL_LOCK  input  1  PLL lock flag; asynchronous to LCD_CLK.
- BTN_USER  input  1  raw user button, active-low (pressed = 0), asynchronous.
- VSYNC  input  1  vertical sync from the LCD timing generator; synchronous to LCD_CLK.
- PAT_SEL  output  3  current pattern index to the pixel datapath.
- BLANK  output  1  1 = datapath must drive black.
- BL_EN  output  1  backlight enable.
- FRAME_CNT  output  16  count of frame starts seen in RUN.
- STATE  output  2  current state, for LED and debug.

Behaviour:
- Reset (BTN_RESET=0, asynchronous) forces:
  - PAT_SEL=0, BLANK=1, BL_EN=0, FRAME_CNT=0, STATE=WAIT_LOCK.
  - Debounced button stable level = 1 (released); debounce counter=0; pending=0.
  - Blank-frame counter=0; VSYNC history register = inactive level.
- Reset release is used directly; the clock-domain cross of reset is handled elsewhere.
- PLL_LOCK and BTN_USER each pass through a 2-flop synchronizer. The synchronized value appears 2 cycles after the input change.
- Frame start:
  - VSYNC is registered once (vs_q).
  - frame_start is a 1-cycle pulse when vs_q is inactive and VSYNC is active, per VSYNC_ACTIVE_LOW.
- Debounce:
  - If the synced button differs from the stable level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level takes the synced value and the counter clears.
  - press = 1-cycle pulse on a stable 1->0 transition. Release produces no event.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Pending advance:
  - press sets pending.
  - Any number of presses before the next frame start gives one advance.
  - A press in the same cycle as frame_start stays pending for the following frame.
- State machine (STATE encoding: WAIT_LOCK=0, BLANKING=1, RUN=2):
  - WAIT_LOCK:
    - BLANK=1, BL_EN=0, pending held at 0.
    - Goes to BLANKING when synced lock=1; the blank-frame counter clears on entry.
  - BLANKING:
    - BLANK=1, BL_EN=0, pending held at 0.
    - Counter increments on each frame_start.
    - On the frame_start that brings the count to BLANK_FRAMES, goes to RUN. BLANK falls and BL_EN rises on the next cycle, registered.
  - RUN:
    - BLANK=0, BL_EN=1.
    - On frame_start: FRAME_CNT increments, wrapping 0xFFFF->0.
    - On frame_start with pending=1: PAT_SEL = (PAT_SEL==NUM_PATTERNS-1) ? 0 : PAT_SEL+1, and pending clears, all in the same cycle.
  - Any state, synced lock=0:
    - Next state is WAIT_LOCK; BLANK=1 and BL_EN=0 from the next cycle; pending clears.
    - PAT_SEL and FRAME_CNT are retained.
    - Lock loss takes priority over frame_start in the same cycle.
- Outputs are registered; there are no combinational paths from inputs.
- VSYNC held constant means frame_start never fires, and the block stays in its current state indefinitely (legal).

Decomposition:
- Shared package lcd_pkg holds:
  - the state enum {WAIT_LOCK, BLANKING, RUN} as a 2-bit typedef;
  - pattern index constants (PAT_CHECKER=0, PAT_BARS=1, PAT_GRAD=2, PAT_SOLID=3);
  - the default debounce count.
- One sub-module, btn_debounce: 2-flop synchronizer, stable register, counter, and press pulse, parameterized by DEBOUNCE_CYCLES. It is reused for later buttons.
- Lock synchronizer, frame-start detect, and FSM stay in lcd_frame_sequencer.

Test Plan:
- Lock bring-up: assert reset, release with PLL_LOCK=0 for 1000 cycles, then lock=1, 6 VSYNC falling edges -> STATE=0 until lock+2 cycles, BLANK=1 through the 4th frame start, BLANK=0 and BL_EN=1 exactly 1 cycle after the 4th, FRAME_CNT=0 then 1 after the 5th.
- Debounced press: in RUN, bounce BTN_USER every 1000 cycles for 20000 cycles, then hold low 100000 cycles -> exactly one press; PAT_SEL 0->1 only on the next frame start, never mid-frame.
- Wrap and multi-press: 3 clean presses within one frame -> single advance. Repeat across 4 frames from PAT_SEL=3 -> sequence 3,0,1,2,3.
- Coincident events: press pulse in the same cycle as frame_start -> PAT_SEL unchanged that frame, advances on the next frame start.
- Lock loss mid-RUN: drop PLL_LOCK for 50 cycles with PAT_SEL=2, FRAME_CNT=10 -> BLANK=1, BL_EN=0 within 3 cycles; PAT_SEL=2 and FRAME_CNT=10 retained; 4 more frames needed before RUN; a press during BLANKING causes no advance.
- Async reset mid-RUN: assert BTN_RESET between clock edges -> all outputs at reset values immediately, before the next clock edge.
